// File: rtl/vga_board_fetch_arbiter.sv
// vga_board_fetch_arbiter
// Shares the single-port board RAM between the VGA scan-out path and the
// game-logic writer. During the horizontal blank ahead of each new cell row
// the row is prefetched into a line buffer; the pixel path reads that buffer
// combinationally. Game accesses are granted only while no prefetch runs.
// Optional feature macro: VGA_FB_OVERRUN_EN (sticky fetch-overrun flag).
module vga_board_fetch_arbiter #(
  parameter int COLS     = 10,
  parameter int ROWS     = 20,
  parameter int CELL_W   = 3,
  parameter int ADDR_W   = 8,
  parameter int CELL_PX  = 16,
  parameter int ORIGIN_Y = 80
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_start,
  input  logic [9:0]        counter_y,
  input  logic [3:0]        disp_col,
  output logic [CELL_W-1:0] disp_color,
  output logic              lb_valid,
  input  logic              gw_req,
  input  logic              gw_we,
  input  logic [ADDR_W-1:0] gw_addr,
  input  logic [CELL_W-1:0] gw_wdata,
  output logic              gw_gnt,
  output logic              gw_rvalid,
  output logic [CELL_W-1:0] gw_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [CELL_W-1:0] ram_wdata,
  input  logic [CELL_W-1:0] ram_rdata,
  output logic              overrun
);

  localparam int              COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int              PX_SH    = $clog2(CELL_PX);
  localparam logic [10:0]     Y_FIRST  = 11'(ORIGIN_Y);
  localparam logic [10:0]     Y_END    = 11'(ORIGIN_Y + ROWS * CELL_PX);
  localparam logic [10:0]     PX_MASK  = 11'(CELL_PX - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              state_r, next_s;
  logic [COL_W-1:0]    col_r;
  logic [ADDR_W-1:0]   row_base_r;
  logic                cap_valid_r;
  logic [COL_W-1:0]    cap_idx_r;
  logic                lb_valid_r;
  logic                rd_pend_r;
  logic [CELL_W-1:0]   lb_r [COLS];

  logic [10:0]         ny_s, off_s, row_s;
  logic                in_range_s, aligned_s, trigger_s, leave_s, fetch_s;
  logic [ADDR_W-1:0]   row_base_s;

  // Next scanline is what the prefetch prepares for; the blank precedes it.
  assign ny_s       = {1'b0, counter_y} + 11'd1;
  assign off_s      = ny_s - Y_FIRST;
  assign row_s      = off_s >> PX_SH;
  assign in_range_s = (ny_s >= Y_FIRST) && (ny_s < Y_END);
  assign aligned_s  = ((off_s & PX_MASK) == 11'd0);
  assign trigger_s  = line_start & in_range_s & aligned_s;
  assign leave_s    = line_start & ~in_range_s;
  assign row_base_s = ADDR_W'(int'(row_s) * COLS);
  assign fetch_s    = (state_r == ST_FETCH);

  // Display path has absolute priority: no grant while fetching or triggering.
  assign gw_gnt    = gw_req & (state_r == ST_IDLE) & ~trigger_s & ~rst;
  assign gw_rvalid = rd_pend_r;
  assign gw_rdata  = rd_pend_r ? ram_rdata : '0;
  assign lb_valid  = lb_valid_r;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= next_s;
  end

  // FSM next-state logic; triggers outside IDLE are ignored.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE:  if (trigger_s) next_s = ST_FETCH; else next_s = ST_IDLE;
      ST_FETCH: if (col_r == COL_LAST) next_s = ST_DRAIN; else next_s = ST_FETCH;
      ST_DRAIN: next_s = ST_IDLE;
      default:  next_s = ST_IDLE;
    endcase
  end

  // Fetch column counter, capture pipeline, buffer-valid and read-return flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_r       <= '0;
      row_base_r  <= '0;
      cap_valid_r <= 1'b0;
      cap_idx_r   <= '0;
      lb_valid_r  <= 1'b0;
      rd_pend_r   <= 1'b0;
    end else begin
      cap_valid_r <= fetch_s;
      cap_idx_r   <= col_r;
      rd_pend_r   <= gw_gnt & ~gw_we;
      if ((state_r == ST_IDLE) && trigger_s) begin
        col_r      <= '0;
        row_base_r <= row_base_s;
      end else if (fetch_s) begin
        col_r      <= col_r + COL_W'(1);
      end
      if (state_r == ST_DRAIN)
        lb_valid_r <= 1'b1;
      else if (((state_r == ST_IDLE) && trigger_s) || leave_s)
        lb_valid_r <= 1'b0;
    end
  end

  // Line buffer: read data lands one cycle after its fetch read was issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < COLS; i++) lb_r[i] <= '0;
    end else begin
      for (int i = 0; i < COLS; i++)
        if (cap_valid_r && (cap_idx_r == COL_W'(i))) lb_r[i] <= ram_rdata;
    end
  end

  // Zero-latency pixel lookup; off-board columns and stale buffer read as 0.
  always_comb begin
    disp_color = '0;
    for (int i = 0; i < COLS; i++)
      if (lb_valid_r && (disp_col == 4'(i))) disp_color = lb_r[i];
  end

  // RAM port mux: fetch reads when fetching, otherwise the granted game access.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (rst) begin
      ram_en = 1'b0;
    end else if (fetch_s) begin
      ram_en   = 1'b1;
      ram_addr = row_base_r + ADDR_W'(col_r);
    end else if (gw_gnt) begin
      ram_en    = 1'b1;
      ram_we    = gw_we;
      ram_addr  = gw_addr;
      ram_wdata = gw_wdata;
    end else begin
      ram_en = 1'b0;
    end
  end

`ifdef VGA_FB_OVERRUN_EN
  logic overrun_r;

  // Sticky flag: a row trigger arrived while the previous fetch was running.
  always_ff @(posedge clk) begin
    if (rst)                                 overrun_r <= 1'b0;
    else if (trigger_s && state_r != ST_IDLE) overrun_r <= 1'b1;
  end

  assign overrun = overrun_r;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_vga_board_fetch_arbiter.sv
// Scoreboard bench for vga_board_fetch_arbiter: expected RAM accesses and
// game read returns are queued by the stimulus and popped by a monitor.
module tb_vga_board_fetch_arbiter;

  logic       clk, rst, line_start;
  logic [9:0] counter_y;
  logic [3:0] disp_col;
  logic [2:0] disp_color;
  logic       lb_valid, gw_req, gw_we, gw_gnt, gw_rvalid;
  logic [7:0] gw_addr, ram_addr;
  logic [2:0] gw_wdata, gw_rdata, ram_wdata, ram_rdata;
  logic       ram_en, ram_we, overrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] addr;
    logic       we;
    logic [2:0] wdata;
  } acc_t;

  acc_t       exp_acc[$];
  logic [2:0] exp_rd[$];
  logic       exp_ovr;

  logic [2:0] mem     [256];
  logic       written [256];

  vga_board_fetch_arbiter dut (
    .clk(clk), .rst(rst), .line_start(line_start), .counter_y(counter_y),
    .disp_col(disp_col), .disp_color(disp_color), .lb_valid(lb_valid),
    .gw_req(gw_req), .gw_we(gw_we), .gw_addr(gw_addr), .gw_wdata(gw_wdata),
    .gw_gnt(gw_gnt), .gw_rvalid(gw_rvalid), .gw_rdata(gw_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board RAM model: unwritten cell a holds a mod 8; 1-cycle read latency.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) written[i] <= 1'b0;
    end else if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr]     <= ram_wdata;
        written[ram_addr] <= 1'b1;
      end else begin
        ram_rdata <= written[ram_addr] ? mem[ram_addr] : 3'(ram_addr % 8);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_acc(input int a, input logic we, input logic [2:0] wd);
    acc_t e;
    e.addr = 8'(a); e.we = we; e.wdata = wd;
    exp_acc.push_back(e);
  endtask

  // Monitor: every RAM access and every game read return must be expected.
  always @(negedge clk) begin
    acc_t e;
    logic [2:0] d;
    if (ram_en) begin
      if (exp_acc.size() == 0) begin
        checks++; errors++;
        $display("FAIL ram_unexpected actual=addr %0d required=no access at %0t", ram_addr, $time);
      end else begin
        e = exp_acc.pop_front();
        chk("ram_addr", 32'(ram_addr), 32'(e.addr));
        chk("ram_we", 32'(ram_we), 32'(e.we));
        if (e.we) chk("ram_wdata", 32'(ram_wdata), 32'(e.wdata));
      end
    end
    if (gw_rvalid) begin
      if (exp_rd.size() == 0) begin
        checks++; errors++;
        $display("FAIL rvalid_unexpected actual=1 required=0 at %0t", $time);
      end else begin
        d = exp_rd.pop_front();
        chk("gw_rdata", 32'(gw_rdata), 32'(d));
      end
    end
  end

  initial begin
`ifdef VGA_FB_OVERRUN_EN
    exp_ovr = 1'b1;
`else
    exp_ovr = 1'b0;
`endif
    rst = 1'b1; line_start = 1'b0; counter_y = 10'd0; disp_col = 4'd0;
    gw_req = 1'b0; gw_we = 1'b0; gw_addr = 8'd0; gw_wdata = 3'd0;
    repeat (3) cyc();
    #3;
    chk("rst_lb_valid", 32'(lb_valid), 32'd0);
    chk("rst_gw_gnt", 32'(gw_gnt), 32'd0);
    chk("rst_gw_rvalid", 32'(gw_rvalid), 32'd0);
    chk("rst_gw_rdata", 32'(gw_rdata), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_disp_color", 32'(disp_color), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    cyc(); rst = 1'b0;

    // Fetch of row 0 after reset.
    cyc();
    for (int c = 0; c < 10; c++) push_acc(c, 1'b0, 3'd0);
    line_start = 1'b1; counter_y = 10'd79;
    #3;
    chk("trig_ram_en", 32'(ram_en), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      cyc(); line_start = 1'b0; counter_y = 10'd0;
      #3;
      chk("fetch_ram_en", 32'(ram_en), 32'(k <= 10));
      chk("fetch_lb_valid", 32'(lb_valid), 32'(k == 12));
    end
    for (int c = 0; c < 10; c++) begin
      cyc(); disp_col = 4'(c);
      #3;
      chk("disp_row0", 32'(disp_color), 32'(c % 8));
    end
    cyc(); disp_col = 4'd12; #3; chk("disp_col12", 32'(disp_color), 32'd0);
    cyc(); disp_col = 4'd10; #3; chk("disp_col10", 32'(disp_color), 32'd0);

    // Row 1 addressing, then a non-boundary line that must not fetch.
    cyc();
    for (int c = 10; c < 20; c++) push_acc(c, 1'b0, 3'd0);
    line_start = 1'b1; counter_y = 10'd95; disp_col = 4'd0;
    for (int k = 1; k <= 12; k++) begin
      cyc(); line_start = 1'b0; counter_y = 10'd0;
      #3;
      chk("row1_lb_valid", 32'(lb_valid), 32'(k == 12));
    end
    chk("row1_col0", 32'(disp_color), 32'd2);
    cyc(); disp_col = 4'd9; #3; chk("row1_col9", 32'(disp_color), 32'd3);
    cyc(); line_start = 1'b1; counter_y = 10'd96;
    #3; chk("nonbound_ram_en", 32'(ram_en), 32'd0);
    repeat (14) begin cyc(); line_start = 1'b0; counter_y = 10'd0; end
    #3; chk("nonbound_lb_valid", 32'(lb_valid), 32'd1);

    // Priority: game read of addr 5 held from the trigger cycle.
    cyc();
    for (int c = 0; c < 10; c++) push_acc(c, 1'b0, 3'd0);
    push_acc(5, 1'b0, 3'd0);
    exp_rd.push_back(3'd5);
    line_start = 1'b1; counter_y = 10'd79;
    gw_req = 1'b1; gw_we = 1'b0; gw_addr = 8'd5;
    #3; chk("prio_gnt_T", 32'(gw_gnt), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      cyc(); line_start = 1'b0; counter_y = 10'd0;
      #3;
      chk("prio_gnt", 32'(gw_gnt), 32'(k == 12));
    end
    cyc(); gw_req = 1'b0;
    #3; chk("prio_rvalid", 32'(gw_rvalid), 32'd1);

    // Write 6 to addr 42, then read it back.
    cyc();
    push_acc(42, 1'b1, 3'd6);
    gw_req = 1'b1; gw_we = 1'b1; gw_addr = 8'd42; gw_wdata = 3'd6;
    #3; chk("wr_gnt", 32'(gw_gnt), 32'd1);
    cyc();
    push_acc(42, 1'b0, 3'd0);
    exp_rd.push_back(3'd6);
    gw_we = 1'b0;
    #3;
    chk("rd_gnt", 32'(gw_gnt), 32'd1);
    chk("wr_no_rvalid", 32'(gw_rvalid), 32'd0);
    cyc(); gw_req = 1'b0;
    #3; chk("rd_rvalid", 32'(gw_rvalid), 32'd1);

    // Out of range line clears the buffer without touching the RAM.
    cyc(); line_start = 1'b1; counter_y = 10'd399; disp_col = 4'd1;
    #3;
    chk("oor_ram_en", 32'(ram_en), 32'd0);
    chk("oor_disp_before", 32'(disp_color), 32'd1);
    cyc(); line_start = 1'b0; counter_y = 10'd0;
    #3;
    chk("oor_lb_valid", 32'(lb_valid), 32'd0);
    chk("oor_disp_color", 32'(disp_color), 32'd0);

    // Second trigger mid-fetch: fetch of row 0 completes unchanged.
    cyc();
    chk("ovr_before", 32'(overrun), 32'd0);
    for (int c = 0; c < 10; c++) push_acc(c, 1'b0, 3'd0);
    line_start = 1'b1; counter_y = 10'd79; disp_col = 4'd9;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      line_start = (k == 3);
      counter_y  = (k == 3) ? 10'd95 : 10'd0;
      #3;
      if (k == 4) chk("overrun_set", 32'(overrun), 32'(exp_ovr));
    end
    chk("ovr_lb_valid", 32'(lb_valid), 32'd1);
    chk("ovr_row_kept", 32'(disp_color), 32'd1);

    // Reset in the middle of a fetch aborts it.
    cyc();
    for (int c = 0; c < 4; c++) push_acc(c, 1'b0, 3'd0);
    line_start = 1'b1; counter_y = 10'd79;
    for (int k = 1; k <= 5; k++) begin
      cyc(); line_start = 1'b0; counter_y = 10'd0;
      rst = (k == 5);
    end
    cyc(); rst = 1'b0;
    #3;
    chk("abort_lb_valid", 32'(lb_valid), 32'd0);
    chk("abort_ram_en", 32'(ram_en), 32'd0);
    chk("abort_overrun", 32'(overrun), 32'd0);
    repeat (14) cyc();
    #3;
    chk("abort_lb_stays", 32'(lb_valid), 32'd0);
    chk("abort_disp", 32'(disp_color), 32'd0);

    cyc();
    chk("acc_queue_empty", 32'(exp_acc.size()), 32'd0);
    chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
